// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the mem_responder block.
//   state_t      - read FSM states (IDLE, WAIT, RESP)
//   *_DEF        - default ADDR_W / DATA_W / RD_WAIT parameter values
//   CNT_W        - width of the wr_cnt / rd_cnt transaction counters
//   WAIT_W       - width of the read wait-state down-counter
//   sat_inc()    - saturating counter increment (holds at all-ones)
package mem_resp_pkg;

  localparam int ADDR_W_DEF  = 6;
  localparam int DATA_W_DEF  = 8;
  localparam int RD_WAIT_DEF = 2;
  localparam int CNT_W       = 16;
  localparam int WAIT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: word storage for mem_responder.
// Synchronous write, combinational (asynchronous) read; contents are never
// reset so data survives a responder reset.
// Ports:
//   clk    - clock, write on posedge
//   we     - write enable
//   waddr  - write word address
//   wdata  - write word (data, plus parity bit when parity is built in)
//   raddr  - read word address
//   rdata  - read word, follows raddr combinationally
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_reg [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-port memory responder with zero-wait writes and
// RD_WAIT-wait-state reads.
// A request is taken at a posedge with en=1 while ready=1. Writes complete at
// that edge. Reads latch the address and walk IDLE -> WAIT -> RESP -> IDLE;
// the RESP cycle fetches the word and the registered rvalid/rdata pulse
// appears in the following cycle, so acceptance at edge N yields rvalid in
// the cycle after edge N+RD_WAIT+1.
// Optional feature (macro MEM_RESPONDER_PARITY_EN): an even-parity bit is
// stored with each word, par_inj flips it on write, par_err flags a mismatch
// alongside rvalid.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   en, wr          - request strobe, 1=write / 0=read
//   addr, wdata     - word address, write data
//   ready           - high only in IDLE (request can be accepted)
//   rdata, rvalid   - read data (0 unless rvalid), one-cycle response pulse
//   wr_cnt, rd_cnt  - saturating accepted-write / completed-read counters
//   par_inj,par_err - parity injection / parity error (macro builds only)
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_WAIT = RD_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_RESPONDER_PARITY_EN
  input  logic              par_inj,
  output logic              par_err,
`endif
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

`ifdef MEM_RESPONDER_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  state_t              state_reg;
  logic                ready_reg;
  logic                rvalid_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic [CNT_W-1:0]    wr_cnt_reg;
  logic [CNT_W-1:0]    rd_cnt_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;

  logic                wr_acc;
  logic                rd_acc;
  logic [WORD_W-1:0]   wword;
  logic [WORD_W-1:0]   rword;

  // ready_reg is high exactly when the FSM sits in IDLE.
  assign wr_acc = en && ready_reg && wr;
  assign rd_acc = en && ready_reg && !wr;

`ifdef MEM_RESPONDER_PARITY_EN
  logic par_err_reg;
  // Stored bit makes the whole word even; par_inj deliberately breaks that.
  assign wword   = {(^wdata) ^ par_inj, wdata};
  assign par_err = par_err_reg;
`else
  assign wword   = wdata;
`endif

  mem_resp_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (addr),
    .wdata (wword),
    .raddr (addr_reg),
    .rdata (rword)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ready_reg    <= 1'b1;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
      wr_cnt_reg   <= '0;
      rd_cnt_reg   <= '0;
      wait_cnt_reg <= '0;
      addr_reg     <= '0;
`ifdef MEM_RESPONDER_PARITY_EN
      par_err_reg  <= 1'b0;
`endif
    end else begin
      // Response outputs are single-cycle pulses; rdata is zero otherwise.
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
`ifdef MEM_RESPONDER_PARITY_EN
      par_err_reg <= 1'b0;
`endif
      if (wr_acc) begin
        wr_cnt_reg <= sat_inc(wr_cnt_reg);
      end
      case (state_reg)
        IDLE: begin
          if (rd_acc) begin
            addr_reg  <= addr;
            ready_reg <= 1'b0;
            if (RD_WAIT == 0) begin
              state_reg <= RESP;
            end else begin
              state_reg    <= WAIT;
              wait_cnt_reg <= WAIT_W'(RD_WAIT);
            end
          end
        end
        WAIT: begin
          // Leave on the edge where the count reaches 0, so WAIT spans
          // RD_WAIT cycles.
          wait_cnt_reg <= wait_cnt_reg - 1'b1;
          if (wait_cnt_reg == WAIT_W'(1)) begin
            state_reg <= RESP;
          end
        end
        RESP: begin
          rvalid_reg <= 1'b1;
          rdata_reg  <= rword[DATA_W-1:0];
          rd_cnt_reg <= sat_inc(rd_cnt_reg);
`ifdef MEM_RESPONDER_PARITY_EN
          // Odd parity over data+stored bit means the word is corrupt.
          par_err_reg <= ^rword;
`endif
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = ready_reg;
  assign rvalid = rvalid_reg;
  assign rdata  = rdata_reg;
  assign wr_cnt = wr_cnt_reg;
  assign rd_cnt = rd_cnt_reg;

endmodule
